// File: rtl/param_cpu_core.sv
// Parametrised TD4-class accumulator CPU core.
// Two-phase FETCH/EXEC machine advanced by a one-cycle clk_en strobe.
module param_cpu_core #(
  parameter int                DATA_W  = 4,
  parameter int                ADRS_W  = 4,
  parameter logic [DATA_W-1:0] OUT_RST = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  output logic [ADRS_W-1:0]   imem_adrs,
  input  logic [DATA_W+3:0]   imem_data,
  input  logic [DATA_W-1:0]   in_port,
  output logic [DATA_W-1:0]   out_port,
  output logic                halted,
  output logic [ADRS_W-1:0]   d_pc,
  output logic [DATA_W+3:0]   d_inst,
  output logic [DATA_W-1:0]   d_reg_a,
  output logic [DATA_W-1:0]   d_reg_b,
  output logic                d_carry,
  output logic [1:0]          d_phase
);

  localparam int INST_W = DATA_W + 4;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [ADRS_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                carry_q, carry_d;
  logic [INST_W-1:0]   inst_q, inst_d;

  logic [3:0]          op;
  logic [DATA_W-1:0]   imm;
  logic [ADRS_W-1:0]   pc_inc;
  logic [ADRS_W-1:0]   jmp_tgt;
  logic [DATA_W:0]     sum_a;
  logic [DATA_W:0]     sum_b;

  assign op      = inst_q[INST_W-1:DATA_W];
  assign imm     = inst_q[DATA_W-1:0];
  assign pc_inc  = pc_q + ADRS_W'(1);
  assign jmp_tgt = imm[ADRS_W-1:0];
  assign sum_a   = {1'b0, a_q} + {1'b0, imm};
  assign sum_b   = {1'b0, b_q} + {1'b0, imm};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    inst_d  = inst_q;
    if (clk_en) begin
      unique case (state_q)
        FETCH: begin
          inst_d  = imem_data;
          state_d = EXEC;
        end
        EXEC: begin
          pc_d    = pc_inc;
          carry_d = 1'b0;
          state_d = FETCH;
          case (op)
            4'b0000: {carry_d, a_d} = sum_a;
            4'b0101: {carry_d, b_d} = sum_b;
            4'b0011: a_d = imm;
            4'b0111: b_d = imm;
            4'b0001: a_d = b_q;
            4'b0100: b_d = a_q;
            4'b0010: a_d = in_port;
            4'b0110: b_d = in_port;
            4'b1001: out_d = b_q;
            4'b1011: out_d = imm;
            4'b1111: pc_d = jmp_tgt;
            4'b1110: pc_d = carry_q ? pc_inc : jmp_tgt;
            4'b1000: begin
              pc_d    = pc_q;
              carry_d = carry_q;
              state_d = HALT;
            end
            default: ;
          endcase
        end
        HALT: ;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= OUT_RST;
      carry_q <= 1'b0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      inst_q  <= inst_d;
    end
  end

  assign imem_adrs = pc_q;
  assign out_port  = out_q;
  assign halted    = (state_q == HALT);
  assign d_pc      = pc_q;
  assign d_inst    = inst_q;
  assign d_reg_a   = a_q;
  assign d_reg_b   = b_q;
  assign d_carry   = carry_q;
  assign d_phase   = state_q;

endmodule

// File: tb/tb_param_cpu_core.sv
// Bench for param_cpu_core: directed programs plus random programs
// checked against an instruction-level model.
module tb_param_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic [3:0]  imem_adrs;
  logic [7:0]  imem_data;
  logic [3:0]  in_port = '0;
  logic [3:0]  out_port;
  logic        halted;
  logic [3:0]  d_pc;
  logic [7:0]  d_inst;
  logic [3:0]  d_reg_a;
  logic [3:0]  d_reg_b;
  logic        d_carry;
  logic [1:0]  d_phase;

  logic        clk_en2 = 1'b0;
  logic [5:0]  imem_adrs2;
  logic [11:0] imem_data2;
  logic [7:0]  in_port2 = '0;
  logic [7:0]  out_port2;
  logic        halted2;
  logic [5:0]  d_pc2;
  logic [11:0] d_inst2;
  logic [7:0]  d_reg_a2;
  logic [7:0]  d_reg_b2;
  logic        d_carry2;
  logic [1:0]  d_phase2;

  logic [7:0]  rom  [16];
  logic [11:0] rom2 [64];

  int n_checks = 0;
  int n_fail   = 0;

  int m_pc, m_a, m_b, m_c, m_out, m_inst, m_phase;
  bit m_halt;

  always #5 clk = ~clk;

  assign imem_data  = rom[imem_adrs];
  assign imem_data2 = rom2[imem_adrs2];

  param_cpu_core dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .imem_adrs(imem_adrs), .imem_data(imem_data),
    .in_port(in_port), .out_port(out_port), .halted(halted),
    .d_pc(d_pc), .d_inst(d_inst), .d_reg_a(d_reg_a),
    .d_reg_b(d_reg_b), .d_carry(d_carry), .d_phase(d_phase)
  );

  param_cpu_core #(.DATA_W(8), .ADRS_W(6), .OUT_RST(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .clk_en(clk_en2),
    .imem_adrs(imem_adrs2), .imem_data(imem_data2),
    .in_port(in_port2), .out_port(out_port2), .halted(halted2),
    .d_pc(d_pc2), .d_inst(d_inst2), .d_reg_a(d_reg_a2),
    .d_reg_b(d_reg_b2), .d_carry(d_carry2), .d_phase(d_phase2)
  );

  logic [27:0] dut_vec;
  assign dut_vec = {d_inst, halted, d_phase, d_pc,
                    d_reg_a, d_reg_b, d_carry, out_port};

  function automatic logic [27:0] exp_vec();
    logic [7:0] i8;
    logic [1:0] ph;
    logic [3:0] p4, a4, b4, o4;
    logic       c1;
    i8 = 8'(m_inst);
    ph = 2'(m_phase);
    p4 = 4'(m_pc);
    a4 = 4'(m_a);
    b4 = 4'(m_b);
    o4 = 4'(m_out);
    c1 = (m_c != 0);
    return {i8, m_halt, ph, p4, a4, b4, c1, o4};
  endfunction

  // Architectural model: one call per instruction phase.
  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0;
    m_out = 0; m_inst = 0; m_phase = 0; m_halt = 0;
  endtask

  task automatic model_fetch();
    if (m_halt) return;
    m_inst  = int'(rom[m_pc]);
    m_phase = 1;
  endtask

  task automatic model_exec(input int inp);
    int op, im, s, npc, nc;
    if (m_halt) return;
    op  = m_inst / 16;
    im  = m_inst % 16;
    npc = (m_pc + 1) % 16;
    nc  = 0;
    case (op)
      0:  begin s = m_a + im; m_a = s % 16; nc = s / 16; end
      5:  begin s = m_b + im; m_b = s % 16; nc = s / 16; end
      3:  m_a = im;
      7:  m_b = im;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = inp;
      6:  m_b = inp;
      9:  m_out = m_b;
      11: m_out = im;
      15: npc = im;
      14: if (m_c == 0) npc = im;
      8:  begin m_halt = 1; m_phase = 2; return; end
      default: ;
    endcase
    m_pc = npc;
    m_c = nc;
    m_phase = 0;
  endtask

  task automatic strobe();
    @(negedge clk);
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic strobe2();
    @(negedge clk);
    clk_en2 = 1'b1;
    @(negedge clk);
    clk_en2 = 1'b0;
  endtask

  task automatic run_instr();
    strobe();
    model_fetch();
    strobe();
    model_exec(int'(in_port));
  endtask

  task automatic do_reset();
    clk_en = 1'b0;
    clk_en2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_rom(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) rom[i] = fill;
  endtask

  task automatic test_reset();
    fill_rom(8'hC0);
    rom[0] = 8'hB7;
    rom[1] = 8'h33;
    rom[2] = 8'h72;
    rom[3] = 8'h05;
    do_reset();
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_init: got %h want %h", dut_vec, exp_vec());
    end
    n_checks++;
    if (out_port2 !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_out_rst: got %h want a5", out_port2);
    end
    for (int i = 0; i < 3; i++) run_instr();
    strobe();
    model_fetch();
    n_checks++;
    if (d_phase !== 2'b01 || d_inst !== 8'h05) begin
      n_fail++;
      $display("FAIL reset_pre_exec: got ph=%b inst=%h want 01 05",
               d_phase, d_inst);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h want 0000000", dut_vec);
    end
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_add_carry();
    fill_rom(8'hC0);
    rom[0] = 8'h3E;
    rom[1] = 8'h03;
    rom[2] = 8'h40;
    do_reset();
    run_instr();
    run_instr();
    n_checks++;
    if (d_reg_a !== 4'h1 || d_carry !== 1'b1) begin
      n_fail++;
      $display("FAIL add_carry: got A=%h c=%b want A=1 c=1",
               d_reg_a, d_carry);
    end
    run_instr();
    n_checks++;
    if (d_reg_b !== 4'h1 || d_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL mov_clears_c: got B=%h c=%b want B=1 c=0",
               d_reg_b, d_carry);
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL add_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_jnc();
    fill_rom(8'hC0);
    rom[0] = 8'h31;
    rom[1] = 8'h0F;
    rom[2] = 8'hE0;
    rom[3] = 8'h01;
    rom[4] = 8'hE0;
    do_reset();
    run_instr();
    run_instr();
    run_instr();
    n_checks++;
    if (d_pc !== 4'h3 || d_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL jnc_taken_c: got pc=%h c=%b want pc=3 c=0",
               d_pc, d_carry);
    end
    run_instr();
    run_instr();
    n_checks++;
    if (d_pc !== 4'h0) begin
      n_fail++;
      $display("FAIL jnc_jump: got pc=%h want 0", d_pc);
    end
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL jnc_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_counter();
    int k;
    fill_rom(8'hC0);
    rom[0] = 8'h90;
    rom[1] = 8'h51;
    rom[2] = 8'hE0;
    rom[3] = 8'h80;
    do_reset();
    k = 0;
    for (int n = 0; n < 100 && !halted; n++) begin
      run_instr();
      if (m_inst == 8'h90) begin
        n_checks++;
        if (out_port !== 4'(k)) begin
          n_fail++;
          $display("FAIL counter_out: got %h want %h", out_port, 4'(k));
        end
        k++;
      end
    end
    n_checks++;
    if (halted !== 1'b1 || out_port !== 4'hF || d_pc !== 4'h3) begin
      n_fail++;
      $display("FAIL counter_exit: got h=%b out=%h pc=%h want 1 f 3",
               halted, out_port, d_pc);
    end
  endtask

  task automatic test_clk_en_gating();
    fill_rom(8'hC0);
    rom[5] = 8'h3A;
    rom[9] = 8'h7C;
    do_reset();
    for (int i = 0; i < 5; i++) run_instr();
    strobe();
    model_fetch();
    for (int i = 0; i < 20; i++) begin
      in_port = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL gate_hold %0d: got %h want %h",
                 i, dut_vec, exp_vec());
      end
    end
    strobe();
    model_exec(int'(in_port));
    n_checks++;
    if (d_reg_a !== 4'hA || d_pc !== 4'h6) begin
      n_fail++;
      $display("FAIL gate_resume: got A=%h pc=%h want a 6", d_reg_a, d_pc);
    end
    for (int i = 6; i < 16; i++) run_instr();
    n_checks++;
    if (d_pc !== 4'h0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_halt_in();
    fill_rom(8'hC0);
    rom[0] = 8'h20;
    rom[1] = 8'h80;
    do_reset();
    in_port = 4'h9;
    run_instr();
    n_checks++;
    if (d_reg_a !== 4'h9) begin
      n_fail++;
      $display("FAIL in_a: got %h want 9", d_reg_a);
    end
    run_instr();
    n_checks++;
    if (halted !== 1'b1 || d_phase !== 2'b10 || d_pc !== 4'h1) begin
      n_fail++;
      $display("FAIL halt_enter: got h=%b ph=%b pc=%h want 1 10 1",
               halted, d_phase, d_pc);
    end
    for (int i = 0; i < 6; i++) begin
      in_port = 4'($urandom);
      strobe();
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL halt_frozen %0d: got %h want %h",
                 i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_wide();
    for (int i = 0; i < 64; i++) rom2[i] = 12'hC00;
    rom2[0] = 12'hFC5;
    rom2[5] = 12'h3F0;
    rom2[6] = 12'h020;
    do_reset();
    strobe2();
    strobe2();
    n_checks++;
    if (d_pc2 !== 6'h05 || d_phase2 !== 2'b00) begin
      n_fail++;
      $display("FAIL wide_jmp: got pc=%h ph=%b want 05 00",
               d_pc2, d_phase2);
    end
    for (int i = 0; i < 4; i++) strobe2();
    n_checks++;
    if (d_reg_a2 !== 8'h10 || d_carry2 !== 1'b1 || d_pc2 !== 6'h07) begin
      n_fail++;
      $display("FAIL wide_add: got A=%h c=%b pc=%h want 10 1 07",
               d_reg_a2, d_carry2, d_pc2);
    end
  endtask

  task automatic test_random();
    int op;
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < 16; i++) begin
        op = int'($urandom_range(0, 15));
        if (op == 8 && $urandom_range(0, 3) != 0) op = 14;
        rom[i] = {4'(op), 4'($urandom)};
      end
      do_reset();
      for (int s = 0; s < 30; s++) begin
        in_port = 4'($urandom);
        strobe();
        model_fetch();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL rand_fetch p%0d s%0d: got %h want %h",
                   p, s, dut_vec, exp_vec());
        end
        strobe();
        model_exec(int'(in_port));
        n_checks++;
        if (dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL rand_exec p%0d s%0d: got %h want %h",
                   p, s, dut_vec, exp_vec());
        end
      end
    end
  endtask

  initial begin
    fill_rom(8'hC0);
    for (int i = 0; i < 64; i++) rom2[i] = 12'hC00;
    model_reset();
    test_reset();
    test_add_carry();
    test_jnc();
    test_counter();
    test_clk_en_gating();
    test_halt_in();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
